// File: rtl/system_button_pio.sv
// Avalon-MM input PIO: synchronizes an external input bus, captures selected edges
// into a sticky W1C register and raises a maskable level interrupt.
module system_button_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    // Bus handshake: a write commits at the clock edge where chipselect=1 and
    // write_n=0 (no wait-states); readdata is re-registered every cycle from
    // the address mux, so a read returns data one cycle after address is presented.
    logic                              write_en;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]                  sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [ARM_W-1:0]                  arm_cnt;
    logic                              armed;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_capture;
    logic [WIDTH-1:0]                  raw_edge;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  w1c_bits;
    logic [WIDTH-1:0]                  capture_next;
    logic [31:0]                       rd_next;
    logic                              unused_wdata;

    assign write_en     = chipselect & ~write_n;
    assign sync_q       = sync_chain[SYNC_STAGES-1];
    assign armed        = (arm_cnt == ARM_MAX);
    assign unused_wdata = ^writedata;

    always_comb begin
        raw_edge = '0;
        case (EDGE_TYPE)
            0:       raw_edge = sync_q & ~prev_q;
            1:       raw_edge = ~sync_q & prev_q;
            default: raw_edge = sync_q ^ prev_q;
        endcase
    end

    // Edges are suppressed until the synchronizer has flushed post-reset, so an
    // input held high through reset does not look like a fresh rising edge.
    assign edge_det = armed ? raw_edge : '0;

    always_comb begin
        w1c_bits = '0;
        if (write_en && address == 2'd3) begin
            w1c_bits = writedata[WIDTH-1:0];
        end
    end

    // A new edge beats a simultaneous clear of the same bit.
    assign capture_next = (edge_capture & ~w1c_bits) | edge_det;

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = sync_q;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain   <= '0;
            prev_q       <= '0;
            arm_cnt      <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            sync_chain   <= {sync_chain[SYNC_STAGES-2:0], in_port};
            prev_q       <= sync_q;
            if (arm_cnt != ARM_MAX) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (write_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= capture_next;
            readdata     <= rd_next;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_system_button_pio.sv
// Bench for system_button_pio: three instances (rising, falling, any edge) share
// one stimulus stream and are checked against a delayed-input reference model.
module tb_system_button_pio;

    localparam int W  = 4;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    // clock / reset
    always #5 clk = ~clk;

    system_button_pio #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(SS)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0));
    system_button_pio #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(SS)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .irq(irq1));
    system_button_pio #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(SS)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .irq(irq2));

    // Reference model: the synchronized value is in_port as it was SS-1 edges
    // ago, the "previous" value is SS edges ago; hist[0] is oldest.
    logic [W-1:0] hist [0:SS];
    int           edges_since_reset;
    logic [W-1:0] m_cap  [0:2];
    logic [W-1:0] m_mask [0:2];
    logic [W-1:0] cur_in;

    logic [95:0] exp_rd_q  [$];
    logic [2:0]  exp_irq_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [W-1:0] edge_of(input int t, input logic [W-1:0] s,
                                             input logic [W-1:0] p);
        case (t)
            0:       return s & ~p;
            1:       return ~s & p;
            default: return s ^ p;
        endcase
    endfunction

    // driver: applies one cycle of bus/input stimulus and queues the prediction
    task automatic cycle(input logic rst, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [W-1:0] inp);
        logic [95:0]  er;
        logic [2:0]   ei;
        logic [W-1:0] rdv;
        logic [W-1:0] ev;
        logic         is_armed;
        reset     = rst;
        address   = addr;
        writedata = wd;
        in_port   = inp;
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
        end
        is_armed = (edges_since_reset >= SS + 1);
        er = '0;
        ei = '0;
        for (int t = 0; t < 3; t++) begin
            rdv = '0;
            if (rst) begin
                m_cap[t]  = '0;
                m_mask[t] = '0;
            end else begin
                case (addr)
                    2'd0:    rdv = hist[1];
                    2'd2:    rdv = m_mask[t];
                    2'd3:    rdv = m_cap[t];
                    default: rdv = '0;
                endcase
                ev = is_armed ? edge_of(t, hist[1], hist[0]) : '0;
                if (wr && addr == 2'd3) m_cap[t] = m_cap[t] & ~wd[W-1:0];
                m_cap[t] = m_cap[t] | ev;
                if (wr && addr == 2'd2) m_mask[t] = wd[W-1:0];
            end
            er[t*32 +: 32] = {{(32-W){1'b0}}, rdv};
            ei[t]          = |(m_cap[t] & m_mask[t]);
        end
        if (rst) begin
            for (int i = 0; i <= SS; i++) hist[i] = '0;
            edges_since_reset = 0;
        end else begin
            for (int i = 0; i < SS; i++) hist[i] = hist[i+1];
            hist[SS] = inp;
            edges_since_reset++;
        end
        @(posedge clk);
        exp_rd_q.push_back(er);
        exp_irq_q.push_back(ei);
        #1;
    endtask

    task automatic idle(input logic [1:0] addr, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, addr, $urandom, cur_in);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        cycle(1'b0, 1'b1, addr, d, cur_in);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, cur_in);
    endtask

    // scoreboard monitor: compares each registered output against its prediction
    always @(negedge clk) begin
        logic [95:0] er;
        logic [2:0]  ei;
        logic [31:0] act_rd [0:2];
        logic        act_irq [0:2];
        if (exp_rd_q.size() > 0) begin
            er = exp_rd_q.pop_front();
            ei = exp_irq_q.pop_front();
            act_rd[0] = rd0;   act_rd[1] = rd1;   act_rd[2] = rd2;
            act_irq[0] = irq0; act_irq[1] = irq1; act_irq[2] = irq2;
            for (int t = 0; t < 3; t++) begin
                n_tests++;
                if (act_rd[t] !== er[t*32 +: 32]) begin
                    n_fail++;
                    $display("FAIL readdata[type%0d] t=%0t got %h want %h", t, $time,
                             act_rd[t], er[t*32 +: 32]);
                end
                n_tests++;
                if (act_irq[t] !== ei[t]) begin
                    n_fail++;
                    $display("FAIL irq[type%0d] t=%0t got %b want %b", t, $time,
                             act_irq[t], ei[t]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i <= SS; i++) hist[i] = '0;
        for (int t = 0; t < 3; t++) begin
            m_cap[t]  = '0;
            m_mask[t] = '0;
        end
        edges_since_reset = 0;

        // reset with all inputs held high: no false edge, DATA = F
        cur_in = 4'hF;
        do_reset(3);
        idle(2'd3, 10);
        idle(2'd0, 3);
        idle(2'd1, 2);

        // masked rising edge on bit1, then W1C
        cur_in = 4'h0;
        idle(2'd3, 5);
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h2);
        cur_in = 4'h2;
        idle(2'd3, 5);
        wr(2'd3, 32'h2);
        idle(2'd3, 3);

        // capture with mask 0, then unmask
        wr(2'd2, 32'h0);
        cur_in = 4'h3;
        idle(2'd3, 5);
        wr(2'd2, 32'h1);
        idle(2'd2, 3);

        // edge on bit3 coinciding with a W1C of bit3, then W1C of zero
        cur_in = 4'hB;
        idle(2'd3, 2);
        wr(2'd3, 32'h8);
        idle(2'd3, 2);
        wr(2'd3, 32'h0);
        idle(2'd3, 2);

        // falling edge on bit0
        cur_in = 4'hA;
        idle(2'd3, 5);

        // full capture and mask, then a one-cycle reset
        wr(2'd3, 32'hF);
        cur_in = 4'h0;
        idle(2'd0, 4);
        cur_in = 4'hF;
        idle(2'd3, 4);
        wr(2'd2, 32'hF);
        idle(2'd3, 2);
        do_reset(1);
        idle(2'd3, 2);
        idle(2'd2, 2);
        wr(2'd1, 32'hFFFF_FFFF);
        idle(2'd1, 2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cur_in = cur_in ^ W'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else if ($urandom_range(0, 3) == 0) begin
                wr(2'($urandom_range(0, 3)), $urandom);
            end else begin
                idle(2'($urandom_range(0, 3)), 1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
